// File: rtl/register_file.sv
// Integer register file for the reduced RV32I core: 2**AddrWidth registers, two combinational
// read ports and one synchronous write port, with x0 hardwired to zero.
module register_file #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AddrWidth-1:0] rs1,
   output logic [DataWidth-1:0] rs1_data_out,
   input  logic [AddrWidth-1:0] rs2,
   output logic [DataWidth-1:0] rs2_data_out,
   input  logic [AddrWidth-1:0] rd,
   input  logic                 rd_write_enable,
   input  logic [DataWidth-1:0] rd_data_in
);

   localparam int unsigned NumRegs = 2 ** AddrWidth;

   logic [DataWidth-1:0] regs_q [NumRegs];
   logic                 write_en;

   // Writes to x0 are dropped so entry 0 never leaves its reset value.
   assign write_en = rd_write_enable && (rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (write_en) begin
         regs_q[rd] <= rd_data_in;
      end
   end

   // No write bypass: a same-cycle write to rs1/rs2 shows up only after the edge.
   always_comb begin
      rs1_data_out = '0;
      rs2_data_out = '0;
      if (rs1 != '0) begin
         rs1_data_out = regs_q[rs1];
      end
      if (rs2 != '0) begin
         rs2_data_out = regs_q[rs2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized self-checking bench for register_file.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] rs1;
   logic [DW-1:0] rs1_data_out;
   logic [AW-1:0] rs2;
   logic [DW-1:0] rs2_data_out;
   logic [AW-1:0] rd;
   logic          rd_write_enable;
   logic [DW-1:0] rd_data_in;

   int n_assert;
   int n_fail;

   logic [DW-1:0] model [32];

   register_file #(
      .DataWidth(DW),
      .AddrWidth(AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rs1            (rs1),
      .rs1_data_out   (rs1_data_out),
      .rs2            (rs2),
      .rs2_data_out   (rs2_data_out),
      .rd             (rd),
      .rd_write_enable(rd_write_enable),
      .rd_data_in     (rd_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge, leaving inputs stable around it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] data);
      rd              = idx;
      rd_data_in      = data;
      rd_write_enable = 1'b1;
      tick();
      rd_write_enable = 1'b0;
   endtask

   initial begin
      n_assert        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      rs1             = '0;
      rs2             = '0;
      rd              = 5'd5;
      rd_data_in      = 32'hFFFF_FFFF;
      rd_write_enable = 1'b1;

      // Writes during reset are ignored
      tick();
      tick();
      rs1 = 5'd5;
      rs2 = 5'd31;
      #1;
      check("reset_rs1_during", rs1_data_out, 32'h0);
      check("reset_rs2_during", rs2_data_out, 32'h0);
      #2;
      rst_n           = 1'b1;
      rd_write_enable = 1'b0;
      tick();
      check("reset_rs1_x5", rs1_data_out, 32'h0);
      check("reset_rs2_x31", rs2_data_out, 32'h0);

      // Basic write then combinational read
      write_reg(5'd1, 32'hDEAD_BEEF);
      write_reg(5'd31, 32'h8000_0000);
      rs1 = 5'd1;
      rs2 = 5'd31;
      #1;
      check("basic_x1", rs1_data_out, 32'hDEAD_BEEF);
      check("basic_x31", rs2_data_out, 32'h8000_0000);
      rs1 = 5'd31;
      rs2 = 5'd1;
      #1;
      check("swap_rs1_x31", rs1_data_out, 32'h8000_0000);
      check("swap_rs2_x1", rs2_data_out, 32'hDEAD_BEEF);

      // x0 stays zero
      write_reg(5'd0, 32'h1234_5678);
      rs1 = 5'd0;
      rs2 = 5'd0;
      #1;
      check("x0_rs1", rs1_data_out, 32'h0);
      check("x0_rs2", rs2_data_out, 32'h0);

      // Disabled write leaves register unchanged
      rd              = 5'd3;
      rd_data_in      = 32'hAAAA_5555;
      rd_write_enable = 1'b0;
      tick();
      rs1 = 5'd3;
      #1;
      check("we0_x3", rs1_data_out, 32'h0);

      // Read during write returns old value until the edge
      write_reg(5'd7, 32'h1111_1111);
      rd              = 5'd7;
      rd_data_in      = 32'h2222_2222;
      rd_write_enable = 1'b1;
      rs1             = 5'd7;
      rs2             = 5'd7;
      #1;
      check("rdw_before_rs1", rs1_data_out, 32'h1111_1111);
      check("rdw_before_rs2", rs2_data_out, 32'h1111_1111);
      tick();
      rd_write_enable = 1'b0;
      check("rdw_after_rs1", rs1_data_out, 32'h2222_2222);
      check("rdw_after_rs2", rs2_data_out, 32'h2222_2222);

      // Fill x1..x31 with idx * 0x01010101
      for (int i = 1; i < 32; i++) begin
         write_reg(i[AW-1:0], i * 32'h0101_0101);
      end
      for (int i = 1; i < 32; i++) begin
         rs1 = i[AW-1:0];
         rs2 = AW'(32 - i);
         #1;
         check($sformatf("fill_rs1_x%0d", i), rs1_data_out, i * 32'h0101_0101);
         check($sformatf("fill_rs2_x%0d", 32 - i), rs2_data_out, (32 - i) * 32'h0101_0101);
      end

      // Async reset pulse between edges clears everything at once
      @(negedge clk);
      rs1   = 5'd17;
      rs2   = 5'd31;
      rst_n = 1'b0;
      #1;
      check("async_rs1_x17", rs1_data_out, 32'h0);
      check("async_rs2_x31", rs2_data_out, 32'h0);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      for (int i = 1; i < 32; i++) begin
         rs1 = i[AW-1:0];
         #1;
         check($sformatf("post_reset_x%0d", i), rs1_data_out, 32'h0);
      end

      // Randomized sweep against a reference model
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int n = 0; n < 1000; n++) begin
         rd              = AW'($urandom_range(0, 31));
         rd_data_in      = $urandom;
         rd_write_enable = 1'($urandom_range(0, 1));
         rs1             = AW'($urandom_range(0, 31));
         rs2             = AW'($urandom_range(0, 31));
         #1;
         check($sformatf("rand%0d_rs1_x%0d", n, rs1), rs1_data_out,
               (rs1 == '0) ? 32'h0 : model[rs1]);
         check($sformatf("rand%0d_rs2_x%0d", n, rs2), rs2_data_out,
               (rs2 == '0) ? 32'h0 : model[rs2]);
         @(posedge clk);
         if (rd_write_enable && rd != '0) model[rd] = rd_data_in;
         #1;
      end
      rd_write_enable = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Integer register file for the reduced RV32I core: 32 general-purpose registers of 32 bits each, with two combinational read ports (rs1, rs2) and one synchronous write port (rd). Register x0 is hardwired to zero. The core's execute state reads operands from this block in the same cycle the instruction register updates. Write-back from ALU results, loads, and JAL/JALR link values lands here one clock later.

## Interface
- DataWidth, default 32: width of each register and of the data ports.
- AddrWidth, default 5: register index width; the file holds 2**AddrWidth registers.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears every register to 0.
- rs1  input  AddrWidth  read port 1 index.
- rs1_data_out  output  DataWidth  contents of register rs1; signed in the core's view, raw bits here.
- rs2  input  AddrWidth  read port 2 index.
- rs2_data_out  output  DataWidth  contents of register rs2.
- rd  input  AddrWidth  write index.
- rd_write_enable  input  1  write strobe, sampled on the clk rising edge.
- rd_data_in  input  DataWidth  write data.

## Operation
- Storage: array of 2**AddrWidth words, DataWidth bits each.
- Read ports are purely combinational.
  - rs1_data_out = reg[rs1] and rs2_data_out = reg[rs2], updating within the same cycle the index changes.
  - Index 0 always reads 0.
- Write: on the rising clk edge with rd_write_enable=1 and rd≠0, reg[rd] <= rd_data_in.
  - rd=0 writes are discarded; x0 stays 0 permanently.
  - rd_write_enable=0 leaves all registers unchanged, regardless of rd and rd_data_in.
- No write-to-read bypass. Reading register rd in the same cycle as a write to it returns the old value; the new value appears on the read port right after the edge.
- Both read ports may address the same register, or rd, simultaneously; each returns reg[index] independently.
- Reset: when rst_n is low, all registers are asynchronously forced to 0.
  - Writes are ignored while rst_n is low.
  - The read outputs follow combinationally, so they read 0 during reset.
  - Reset asserted mid-write wins: the register is 0 after reset.
- No other state and no state machine. The file has no error reporting; every index in range is legal.

## Timing
- Read latency: 0 cycles (combinational from rs1/rs2 and register contents).
- Write latency: 1 edge. Data presented with rd_write_enable high in cycle N is readable in cycle N+1.
- Outputs at reset: rs1_data_out = rs2_data_out = 0 for any index.
- Core usage contract:
  - ir (and hence rs1/rs2/rd) updates on the edge entering CpuExecute; operands must be valid in that same cycle.
  - rd_write_enable and rd_data_in are registered in CpuExecute or CpuLoad, so the write commits on the edge ending the following CpuFetch cycle.
  - rd_write_enable is cleared during CpuFetch, giving at most one write per instruction.

## Test plan
- Reset: hold rst_n low, drive writes of 0xFFFFFFFF to x5 → write ignored. Release reset, read rs1=5, rs2=31 → both 0.
- Basic write/read: write x1=0xDEADBEEF, x31=0x80000000 on consecutive edges. Set rs1=1, rs2=31 → 0xDEADBEEF and 0x80000000 combinationally, with no extra cycle.
- x0 protection: write rd=0 data 0x12345678 with enable=1 → rs1=0 reads 0. Write enable=0 with rd=3 data 0xAAAA5555 → x3 unchanged (still 0).
- Read-during-write: x7=0x11111111, then in one cycle write x7=0x22222222 with rs1=rs2=7 → reads 0x11111111 before the edge and 0x22222222 after it.
- Async reset mid-operation: fill x1..x31 with index×0x01010101, pulse rst_n low between clk edges → all reads immediately 0, and remain 0 after release until rewritten.
- Random sweep: 1000 random {rd, data, enable, rs1, rs2} cycles checked against a reference model of 32 words with x0 forced to 0.
